// File: rtl/lsu_ctrl.sv
// Load/store controller between the memory stage and emu_ram: one access per handshake,
// load extension, valid/ready response. Optional misalignment trap: LSU_MISALIGN_CHECK_EN.
module lsu_ctrl #(
   parameter int unsigned ADDR_WIDTH = 32,
   parameter int unsigned DATA_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  rstn,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic                  req_we,
   input  logic [2:0]            req_funct3,
   input  logic [ADDR_WIDTH-1:0] req_addr,
   input  logic [DATA_WIDTH-1:0] req_wdata,
   output logic                  resp_valid,
   input  logic                  resp_ready,
   output logic [DATA_WIDTH-1:0] resp_rdata,
   output logic                  resp_err,
   output logic [2:0]            ram_rwtyp,
   output logic [ADDR_WIDTH-1:0] ram_addr,
   output logic [DATA_WIDTH-1:0] ram_data,
   output logic                  ram_wren,
   output logic                  ram_rden,
   input  logic [DATA_WIDTH-1:0] ram_q
);

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

   state_t                state, state_nxt;
   logic                  we_q;
   logic [2:0]            f3_q;
   logic                  accept;
   logic [2:0]            rwtyp_nxt;
   logic                  misalign;
   logic [DATA_WIDTH-1:0] ext_q;

   assign accept     = req_valid && req_ready;
   assign req_ready  = (state == IDLE);
   assign resp_valid = (state == RESP);
   assign ram_wren   = (state == ISSUE) && we_q;
   assign ram_rden   = (state == ISSUE) && !we_q;

   // funct3[2] only selects zero-extension for loads; size comes from [1:0], 11 treated as word
   always_comb begin
      rwtyp_nxt = 3'd2;
      case (req_funct3[1:0])
         2'b00:   rwtyp_nxt = 3'd0;
         2'b01:   rwtyp_nxt = 3'd1;
         default: rwtyp_nxt = 3'd2;
      endcase
   end

`ifdef LSU_MISALIGN_CHECK_EN
   logic err_q;

   always_comb begin
      misalign = 1'b0;
      case (rwtyp_nxt)
         3'd1:    misalign = req_addr[0];
         3'd2:    misalign = |req_addr[1:0];
         default: misalign = 1'b0;
      endcase
   end

   assign resp_err = err_q;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn)
         err_q <= 1'b0;
      else if (accept)
         err_q <= misalign;
   end
`else
   assign misalign = 1'b0;
   assign resp_err = 1'b0;
`endif

   always_comb begin
      ext_q = ram_q;
      case (f3_q)
         3'b000:  ext_q = {{(DATA_WIDTH-8){ram_q[7]}}, ram_q[7:0]};
         3'b001:  ext_q = {{(DATA_WIDTH-16){ram_q[15]}}, ram_q[15:0]};
         3'b100:  ext_q = {{(DATA_WIDTH-8){1'b0}}, ram_q[7:0]};
         3'b101:  ext_q = {{(DATA_WIDTH-16){1'b0}}, ram_q[15:0]};
         default: ext_q = ram_q;
      endcase
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (accept) state_nxt = misalign ? RESP : ISSUE;
         ISSUE:   state_nxt = we_q ? RESP : WAIT;
         WAIT:    state_nxt = RESP;
         RESP:    if (resp_ready) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn)
         state <= IDLE;
      else
         state <= state_nxt;
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         ram_addr   <= '0;
         ram_data   <= '0;
         ram_rwtyp  <= '0;
         we_q       <= 1'b0;
         f3_q       <= '0;
         resp_rdata <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (accept) begin
                  ram_addr  <= req_addr;
                  ram_data  <= req_wdata;
                  ram_rwtyp <= rwtyp_nxt;
                  we_q      <= req_we;
                  f3_q      <= req_funct3;
                  if (misalign)
                     resp_rdata <= '0;
               end
            end
            ISSUE:   if (we_q) resp_rdata <= '0;
            WAIT:    resp_rdata <= ext_q;
            default: ;
         endcase
      end
   end

endmodule
